bkg_accum_ram: RTL and testbench

BKG_ACCUM_RAM -- requirements
Module: bkg_accum_ram

---
 rtl/bkg_accum_ram.sv | 159 +++++++++++++++
 tb/tb_bkg_accum_ram.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bkg_accum_ram.sv
// Background accumulator: clears a per-address RAM, sums 2^LOG2_FRAMES frames of samples
// per channel, then serves the frame-averaged background by address.
module bkg_accum_ram #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned SAMPLE_W    = 16,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned LOG2_FRAMES = 13
) (
  input  logic                       clk_clk,
  input  logic                       rst_reset,
  input  logic                       enable,
  input  logic                       rearm,
  input  logic                       frame_start,
  input  logic [ADDR_W-1:0]          address,
  input  logic [N_CH*SAMPLE_W-1:0]   data_in_data,
  input  logic                       data_in_valid,
  output logic [N_CH*SAMPLE_W-1:0]   bkg_signal,
  output logic                       bkg_valid,
  output logic                       bkg_sub_status,
  output logic [1:0]                 state_o
);

  localparam int unsigned AccW   = SAMPLE_W + LOG2_FRAMES;
  localparam int unsigned WordW  = N_CH * AccW;
  localparam int unsigned DataW  = N_CH * SAMPLE_W;
  localparam int unsigned Depth  = 1 << ADDR_W;
  localparam int unsigned FcW    = LOG2_FRAMES + 2;
  localparam int unsigned Frames = 1 << LOG2_FRAMES;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StAccum = 2'd2,
    StOut   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [FcW-1:0]    frame_cnt_q, frame_cnt_d;
  logic [FcW-1:0]    frame_eff;

  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [DataW-1:0]  s1_data_q;
  logic              fwd_valid_q;
  logic [ADDR_W-1:0] fwd_addr_q;
  logic [WordW-1:0]  fwd_data_q;
  logic              valid_q;

  logic [WordW-1:0]  mem [Depth];
  logic [WordW-1:0]  ram_q;
  logic [WordW-1:0]  base, sum, wdata;
  logic [AccW:0]     ext;
  logic [ADDR_W-1:0] waddr;
  logic              acc_take, clr_we, acc_we, we;

  // A sample arriving with frame_start already belongs to the frame being opened.
  assign frame_eff = frame_start ? frame_cnt_q + FcW'(1) : frame_cnt_q;
  assign acc_take  = enable && !rearm && data_in_valid && (state_q == StAccum) &&
                     (frame_eff != '0) && (frame_eff <= FcW'(Frames));

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (enable) begin
      if (rearm) begin
        state_d     = StClear;
        clr_cnt_d   = '0;
        frame_cnt_d = '0;
      end else begin
        case (state_q)
          StClear: begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == '1) begin
              state_d     = StAccum;
              frame_cnt_d = '0;
            end
          end
          StAccum: begin
            if (frame_start) begin
              if (frame_cnt_q == FcW'(Frames)) state_d = StOut;
              else frame_cnt_d = frame_cnt_q + FcW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The synchronous read misses the write retired on the previous edge; bypass it.
  always_comb begin
    base = (fwd_valid_q && (fwd_addr_q == s1_addr_q)) ? fwd_data_q : ram_q;
    sum  = '0;
    ext  = '0;
    for (int k = 0; k < N_CH; k++) begin
      ext = {1'b0, base[k*AccW +: AccW]} +
            {{(LOG2_FRAMES+1){1'b0}}, s1_data_q[k*SAMPLE_W +: SAMPLE_W]};
      sum[k*AccW +: AccW] = ext[AccW] ? {AccW{1'b1}} : ext[AccW-1:0];
    end
  end

  // Clearing owns the write port; a stale pending sum is dropped once CLEAR starts.
  assign clr_we = enable && (state_q == StClear);
  assign acc_we = s1_valid_q && (state_q != StClear);
  assign we     = clr_we || acc_we;
  assign waddr  = clr_we ? clr_cnt_q : s1_addr_q;
  assign wdata  = clr_we ? '0 : sum;

  always_ff @(posedge clk_clk) begin
    if (we) mem[waddr] <= wdata;
    ram_q <= mem[address];
  end

  always_ff @(posedge clk_clk or posedge rst_reset) begin
    if (rst_reset) begin
      state_q     <= StIdle;
      clr_cnt_q   <= '0;
      frame_cnt_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_data_q   <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      s1_valid_q  <= acc_take;
      if (acc_take) begin
        s1_addr_q <= address;
        s1_data_q <= data_in_data;
      end
      fwd_valid_q <= acc_we;
      if (acc_we) begin
        fwd_addr_q <= s1_addr_q;
        fwd_data_q <= sum;
      end
      valid_q <= data_in_valid;
    end
  end

  always_comb begin
    bkg_signal = '0;
    if (state_q == StOut) begin
      for (int k = 0; k < N_CH; k++) begin
        bkg_signal[k*SAMPLE_W +: SAMPLE_W] = ram_q[k*AccW + LOG2_FRAMES +: SAMPLE_W];
      end
    end
  end

  assign bkg_valid      = valid_q && (state_q != StClear);
  assign bkg_sub_status = (state_q == StOut);
  assign state_o        = state_q;

endmodule

// File: tb/tb_bkg_accum_ram.sv
// Directed bench for bkg_accum_ram with N_CH=2, SAMPLE_W=16, ADDR_W=8, LOG2_FRAMES=2.
module tb_bkg_accum_ram;

  logic        clk_clk = 1'b0;
  logic        rst_reset = 1'b1;
  logic        enable = 1'b0;
  logic        rearm = 1'b0;
  logic        frame_start = 1'b0;
  logic [7:0]  address = '0;
  logic [31:0] data_in_data = '0;
  logic        data_in_valid = 1'b0;
  logic [31:0] bkg_signal;
  logic        bkg_valid;
  logic        bkg_sub_status;
  logic [1:0]  state_o;

  int n_tests = 0;
  int n_fail  = 0;

  bkg_accum_ram #(
    .N_CH(2), .SAMPLE_W(16), .ADDR_W(8), .LOG2_FRAMES(2)
  ) dut (
    .clk_clk(clk_clk), .rst_reset(rst_reset), .enable(enable), .rearm(rearm),
    .frame_start(frame_start), .address(address), .data_in_data(data_in_data),
    .data_in_valid(data_in_valid), .bkg_signal(bkg_signal), .bkg_valid(bkg_valid),
    .bkg_sub_status(bkg_sub_status), .state_o(state_o)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic cyc();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic drive(input logic fs, input logic v, input logic [7:0] a,
                       input logic [15:0] c0, input logic [15:0] c1);
    frame_start   = fs;
    data_in_valid = v;
    address       = a;
    data_in_data  = {c1, c0};
    cyc();
    frame_start   = 1'b0;
    data_in_valid = 1'b0;
  endtask

  task automatic do_rearm(input string tag);
    enable = 1'b1;
    rearm  = 1'b1;
    cyc();
    rearm  = 1'b0;
    n_tests++;
    if (state_o !== 2'd1) begin
      n_fail++;
      $display("FAIL %s_enter_clear: state_o=%0d expected 1", tag, state_o);
    end
    repeat (256) cyc();
    n_tests++;
    if (state_o !== 2'd2) begin
      n_fail++;
      $display("FAIL %s_to_accum: state_o=%0d expected 2", tag, state_o);
    end
  endtask

  task automatic test_reset();
    rst_reset = 1'b1;
    enable    = 1'b1;
    repeat (3) cyc();
    n_tests++;
    if (state_o !== 2'd0 || bkg_valid !== 1'b0 || bkg_sub_status !== 1'b0 ||
        bkg_signal !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: state=%0d valid=%b status=%b sig=%h expected 0/0/0/0",
               state_o, bkg_valid, bkg_sub_status, bkg_signal);
    end
    rst_reset = 1'b0;
    drive(1'b1, 1'b1, 8'd1, 16'd5, 16'd5);
    n_tests++;
    if (state_o !== 2'd0 || bkg_valid !== 1'b1 || bkg_signal !== 32'd0) begin
      n_fail++;
      $display("FAIL idle_needs_rearm: state=%0d valid=%b sig=%h expected 0/1/0",
               state_o, bkg_valid, bkg_signal);
    end
  endtask

  task automatic test_clear();
    int bad = 0;
    rearm         = 1'b1;
    data_in_valid = 1'b1;
    cyc();
    rearm = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (state_o !== 2'd1 || bkg_valid !== 1'b0) bad++;
      cyc();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL clear_window: %0d bad cycles expected 0", bad);
    end
    n_tests++;
    if (state_o !== 2'd2 || bkg_valid !== 1'b1 || bkg_signal !== 32'd0) begin
      n_fail++;
      $display("FAIL clear_exit: state=%0d valid=%b sig=%h expected 2/1/0",
               state_o, bkg_valid, bkg_signal);
    end
    data_in_valid = 1'b0;
  endtask

  task automatic test_accum();
    drive(1'b0, 1'b1, 8'd5, 16'd999, 16'd999);
    for (int f = 0; f < 4; f++) begin
      drive(1'b1, 1'b1, 8'd5, 16'(100 + 4 * f), 16'd8);
      drive(1'b0, 1'b0, 8'd0, 16'd0, 16'd0);
    end
    n_tests++;
    if (state_o !== 2'd2) begin
      n_fail++;
      $display("FAIL accum_hold: state_o=%0d expected 2", state_o);
    end
    drive(1'b1, 1'b0, 8'd0, 16'd0, 16'd0);
    n_tests++;
    if (state_o !== 2'd3 || bkg_sub_status !== 1'b1 || bkg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL enter_out: state=%0d status=%b valid=%b expected 3/1/0",
               state_o, bkg_sub_status, bkg_valid);
    end
    drive(1'b0, 1'b1, 8'd5, 16'd0, 16'd0);
    n_tests++;
    if (bkg_valid !== 1'b1 || bkg_signal !== {16'd8, 16'd106}) begin
      n_fail++;
      $display("FAIL readout_addr5: valid=%b sig=%h expected 1/%h",
               bkg_valid, bkg_signal, {16'd8, 16'd106});
    end
  endtask

  task automatic test_back_to_back();
    do_rearm("b2b");
    for (int f = 0; f < 4; f++) begin
      drive(1'b1, 1'b1, 8'd3, 16'd10, 16'd0);
      drive(1'b0, 1'b1, 8'd3, 16'd20, 16'd0);
      drive(1'b0, 1'b1, 8'd4, 16'd5, 16'd0);
    end
    drive(1'b1, 1'b0, 8'd0, 16'd0, 16'd0);
    drive(1'b0, 1'b1, 8'd3, 16'd0, 16'd0);
    n_tests++;
    if (bkg_signal !== {16'd0, 16'd30}) begin
      n_fail++;
      $display("FAIL b2b_addr3: sig=%h expected %h", bkg_signal, {16'd0, 16'd30});
    end
    drive(1'b0, 1'b1, 8'd4, 16'd0, 16'd0);
    n_tests++;
    if (bkg_signal !== {16'd0, 16'd5}) begin
      n_fail++;
      $display("FAIL b2b_addr4: sig=%h expected %h", bkg_signal, {16'd0, 16'd5});
    end
  endtask

  task automatic test_saturate();
    do_rearm("sat");
    for (int f = 0; f < 4; f++) begin
      drive(1'b1, 1'b1, 8'd7, 16'hFFFF, 16'd0);
      repeat (7) drive(1'b0, 1'b1, 8'd7, 16'hFFFF, 16'd0);
    end
    drive(1'b1, 1'b0, 8'd0, 16'd0, 16'd0);
    drive(1'b0, 1'b1, 8'd7, 16'd0, 16'd0);
    n_tests++;
    if (bkg_signal !== {16'd0, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL saturate_addr7: sig=%h expected %h", bkg_signal, {16'd0, 16'hFFFF});
    end
  endtask

  task automatic test_rearm_mid();
    do_rearm("mid1");
    for (int f = 0; f < 2; f++) drive(1'b1, 1'b1, 8'd9, 16'd1000, 16'd0);
    do_rearm("mid2");
    for (int f = 0; f < 4; f++) drive(1'b1, 1'b1, 8'd9, 16'd40, 16'd0);
    drive(1'b1, 1'b0, 8'd0, 16'd0, 16'd0);
    drive(1'b0, 1'b1, 8'd9, 16'd0, 16'd0);
    n_tests++;
    if (bkg_signal !== {16'd0, 16'd40}) begin
      n_fail++;
      $display("FAIL rearm_mid_addr9: sig=%h expected %h", bkg_signal, {16'd0, 16'd40});
    end
  endtask

  task automatic test_enable();
    do_rearm("en");
    for (int f = 0; f < 4; f++) drive(1'b1, 1'b1, 8'd11, 16'd20, 16'd0);
    enable = 1'b0;
    drive(1'b1, 1'b1, 8'd11, 16'd400, 16'd0);
    drive(1'b0, 1'b1, 8'd11, 16'd400, 16'd0);
    n_tests++;
    if (state_o !== 2'd2) begin
      n_fail++;
      $display("FAIL enable_low_frame: state_o=%0d expected 2", state_o);
    end
    enable = 1'b1;
    drive(1'b1, 1'b0, 8'd0, 16'd0, 16'd0);
    n_tests++;
    if (state_o !== 2'd3) begin
      n_fail++;
      $display("FAIL enable_out: state_o=%0d expected 3", state_o);
    end
    drive(1'b0, 1'b1, 8'd11, 16'd0, 16'd0);
    n_tests++;
    if (bkg_signal !== {16'd0, 16'd20}) begin
      n_fail++;
      $display("FAIL enable_addr11: sig=%h expected %h", bkg_signal, {16'd0, 16'd20});
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_accum();
    test_back_to_back();
    test_saturate();
    test_rearm_mid();
    test_enable();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
